// File: rtl/ram_sdp.sv
// Simple dual-port RAM: byte-enabled writes, 1/2-cycle pipelined reads and a zeroing clear sweep.
// Define RAM_SDP_PARITY_EN to store and check one even-parity bit per byte.
module ram_sdp #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned RD_LATENCY     = 1,
    parameter int unsigned COLLISION_MODE = 0
) (
    input  logic                    i_clk_ram,
    input  logic                    i_rstn_ram,
    input  logic                    i_en_ram,
    input  logic                    i_we_ram,
    input  logic [DATA_WIDTH/8-1:0] i_be_ram,
    input  logic [ADDR_WIDTH-1:0]   i_waddr_ram,
    input  logic [DATA_WIDTH-1:0]   i_wdata_ram,
    input  logic                    i_re_ram,
    input  logic [ADDR_WIDTH-1:0]   i_raddr_ram,
    input  logic                    i_clr_ram,
    output logic [DATA_WIDTH-1:0]   o_rdata_ram,
    output logic                    o_rvalid_ram,
    output logic                    o_busy_ram,
    output logic                    o_perr_ram
);
    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {StClear, StIdle} state_e;

    state_e                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_addr, w_clr_addr_nxt;
    logic                  w_busy, w_wr_acc, w_rd_acc, w_collide;
    logic [DATA_WIDTH-1:0] w_wmask, w_wr_word, w_rd_word;
    logic                  w_rd_perr;
    logic                  w_s_valid, w_s_perr;
    logic [DATA_WIDTH-1:0] w_s_data;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid, r_perr;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk_ram or negedge i_rstn_ram) begin
        if (!i_rstn_ram) begin
            r_state    <= StClear;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    // The sweep address wraps back to 0 on the last word, ready for the next sweep.
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = '0;
        unique case (r_state)
            StClear: begin
                w_clr_addr_nxt = r_clr_addr + 1'b1;
                if (&r_clr_addr) w_state_nxt = StIdle;
            end
            StIdle: begin
                if (i_clr_ram) w_state_nxt = StClear;
            end
        endcase
    end

    always_comb begin
        w_busy = (r_state == StClear);
    end

    assign o_busy_ram = w_busy;
    assign w_wr_acc   = i_en_ram & i_we_ram & ~w_busy;
    assign w_rd_acc   = i_en_ram & i_re_ram & ~w_busy;
    assign w_collide  = w_wr_acc && (i_waddr_ram == i_raddr_ram);

    always_comb begin
        w_wmask = '0;
        for (int i = 0; i < NB; i++) w_wmask[8*i +: 8] = {8{i_be_ram[i]}};
    end

    assign w_wr_word = (r_mem[i_waddr_ram] & ~w_wmask) | (i_wdata_ram & w_wmask);
    assign w_rd_word = (COLLISION_MODE == 1 && w_collide) ? w_wr_word : r_mem[i_raddr_ram];

    always_ff @(posedge i_clk_ram) begin
        if (w_busy) r_mem[r_clr_addr] <= '0;
        else if (w_wr_acc) r_mem[i_waddr_ram] <= w_wr_word;
    end

`ifdef RAM_SDP_PARITY_EN
    logic [NB-1:0] r_par [DEPTH];
    logic [NB-1:0] w_wr_par, w_rd_par;

    function automatic logic [NB-1:0] f_par(input logic [DATA_WIDTH-1:0] d);
        logic [NB-1:0] p;
        p = '0;
        for (int i = 0; i < NB; i++) p[i] = ^d[8*i +: 8];
        return p;
    endfunction

    // Unwritten bytes keep their stored parity so an existing error is not masked.
    assign w_wr_par  = (r_par[i_waddr_ram] & ~i_be_ram) | (f_par(i_wdata_ram) & i_be_ram);
    assign w_rd_par  = (COLLISION_MODE == 1 && w_collide) ? w_wr_par : r_par[i_raddr_ram];
    assign w_rd_perr = |(w_rd_par ^ f_par(w_rd_word));

    always_ff @(posedge i_clk_ram) begin
        if (w_busy) r_par[r_clr_addr] <= '0;
        else if (w_wr_acc) r_par[i_waddr_ram] <= w_wr_par;
    end
`else
    assign w_rd_perr = 1'b0;
`endif

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                  r_p1_valid, r_p1_perr;
            logic [DATA_WIDTH-1:0] r_p1_data;

            always_ff @(posedge i_clk_ram or negedge i_rstn_ram) begin
                if (!i_rstn_ram) begin
                    r_p1_valid <= 1'b0;
                    r_p1_perr  <= 1'b0;
                    r_p1_data  <= '0;
                end else begin
                    r_p1_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_p1_data <= w_rd_word;
                        r_p1_perr <= w_rd_perr;
                    end
                end
            end

            assign w_s_valid = r_p1_valid;
            assign w_s_data  = r_p1_data;
            assign w_s_perr  = r_p1_perr;
        end else begin : g_lat1
            assign w_s_valid = w_rd_acc;
            assign w_s_data  = w_rd_word;
            assign w_s_perr  = w_rd_perr;
        end
    endgenerate

    always_ff @(posedge i_clk_ram or negedge i_rstn_ram) begin
        if (!i_rstn_ram) begin
            r_rvalid <= 1'b0;
            r_perr   <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_s_valid;
            r_perr   <= w_s_valid & w_s_perr;
            if (w_s_valid) r_rdata <= w_s_data;
        end
    end

    assign o_rdata_ram  = r_rdata;
    assign o_rvalid_ram = r_rvalid;
    assign o_perr_ram   = r_perr;
endmodule

// File: tb/tb_ram_sdp.sv
// Randomized scoreboard bench for ram_sdp (32-bit x 16 words); honours RAM_SDP_PARITY_EN.
module tb_ram_sdp;
    parameter int RD_LAT = 1;
    parameter int COLL   = 0;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        en, we, re, clr;
    logic [3:0]  be, waddr, raddr;
    logic [31:0] wdata;
    logic [31:0] o_rdata;
    logic        o_rvalid, o_busy, o_perr;

    ram_sdp #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .RD_LATENCY(RD_LAT), .COLLISION_MODE(COLL)
    ) dut (
        .i_clk_ram(clk), .i_rstn_ram(rstn), .i_en_ram(en), .i_we_ram(we), .i_be_ram(be),
        .i_waddr_ram(waddr), .i_wdata_ram(wdata), .i_re_ram(re), .i_raddr_ram(raddr),
        .i_clr_ram(clr), .o_rdata_ram(o_rdata), .o_rvalid_ram(o_rvalid), .o_busy_ram(o_busy),
        .o_perr_ram(o_perr)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] data; bit perr; int due;} exp_t;
    exp_t        sb[$];
    int          n_pass = 0, n_total = 0, cyc = 0;
    logic [31:0] m_mem [16];
    logic [3:0]  m_bad [16];
    int          m_busy_left = 0;
    logic [31:0] m_last = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic model_wipe();
        for (int i = 0; i < 16; i++) begin
            m_mem[i] = '0;
            m_bad[i] = '0;
        end
    endtask

    // Monitor: pops one expectation per rvalid pulse, checks data, parity flag and arrival cycle.
    always @(negedge clk) begin
        exp_t e;
        if (o_rvalid) begin
            if (sb.size() == 0) begin
                chk(1'b0, "rvalid_unexpected", o_rdata, 32'h0);
            end else begin
                e = sb.pop_front();
                chk(o_rdata === e.data, "rdata", o_rdata, e.data);
                chk(o_perr === e.perr, "perr", {31'h0, o_perr}, {31'h0, e.perr});
                chk(cyc == e.due, "rvalid_latency", cyc, e.due);
                m_last = e.data;
            end
        end else begin
            chk(o_rdata === m_last, "rdata_hold", o_rdata, m_last);
            if (sb.size() > 0 && sb[0].due < cyc) begin
                chk(1'b0, "rvalid_missing", cyc, sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    // One clock of stimulus; the model decides acceptance from its own busy count.
    task automatic step(input bit i_en, input bit i_we, input logic [3:0] i_be,
                        input logic [3:0] i_wa, input logic [31:0] i_wd, input bit i_re,
                        input logic [3:0] i_ra, input bit i_clr);
        bit   busy;
        exp_t e;
        en = i_en; we = i_we; be = i_be; waddr = i_wa; wdata = i_wd;
        re = i_re; raddr = i_ra; clr = i_clr;
        busy = (m_busy_left != 0);
        chk(o_busy === busy, "busy", {31'h0, o_busy}, {31'h0, busy});
        if (!busy && i_en && i_re) begin
            e.data = m_mem[i_ra];
            e.perr = |m_bad[i_ra];
            if (COLL == 1 && i_we && i_wa == i_ra) begin
                e.data = merge(m_mem[i_ra], i_wd, i_be);
                e.perr = |(m_bad[i_ra] & ~i_be);
            end
            e.due = cyc + RD_LAT;
            sb.push_back(e);
        end
        if (!busy && i_en && i_we) begin
            m_mem[i_wa] = merge(m_mem[i_wa], i_wd, i_be);
            m_bad[i_wa] = m_bad[i_wa] & ~i_be;
        end
        if (busy) m_busy_left--;
        else if (i_clr) begin
            m_busy_left = 16;
            model_wipe();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 4'h0, 4'h0, 32'h0, 0, 4'h0, 0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        step(1, 1, b, a, d, 0, 4'h0, 0);
    endtask

    task automatic rd(input logic [3:0] a);
        step(1, 0, 4'h0, 4'h0, 32'h0, 1, a, 0);
    endtask

    task automatic rnd_step(input int clr_odds);
        logic [3:0] wa;
        wa = 4'($urandom_range(0, 15));
        step($urandom_range(0, 7) != 0, $urandom_range(0, 1), 4'($urandom), wa, $urandom,
             $urandom_range(0, 1), ($urandom_range(0, 2) == 0) ? wa : 4'($urandom),
             clr_odds > 0 && $urandom_range(1, clr_odds) == 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(o_rdata === 32'h0, {tag, "_rdata"}, o_rdata, 32'h0);
        chk(o_rvalid === 1'b0, {tag, "_rvalid"}, {31'h0, o_rvalid}, 32'h0);
        chk(o_perr === 1'b0, {tag, "_perr"}, {31'h0, o_perr}, 32'h0);
        chk(o_busy === 1'b1, {tag, "_busy"}, {31'h0, o_busy}, 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        en = 0; we = 0; re = 0; clr = 0; be = '0; waddr = '0; raddr = '0; wdata = '0;
        model_wipe();
        #1 rstn = 1'b0;
        #2 check_reset_outputs("por");
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        m_busy_left = 16;

        // Sweep with requests that must all be dropped, then read every word back as zero.
        repeat (16) rnd_step(0);
        for (int a = 0; a < 16; a++) rd(4'(a));

        wr(4'd3, 32'hA5A5_1234, 4'b1111);
        wr(4'd3, 32'hFFFF_FFFF, 4'b0001);
        rd(4'd3);
        wr(4'd3, 32'h0BAD_F00D, 4'b0000);
        rd(4'd3);

        wr(4'd5, 32'h1111_1111, 4'b1111);
        step(1, 1, 4'b1111, 4'd5, 32'h2222_2222, 1, 4'd5, 0);
        rd(4'd5);
        step(1, 1, 4'b0110, 4'd6, 32'h3333_3333, 1, 4'd6, 0);
        step(1, 1, 4'b1111, 4'd7, 32'h4444_4444, 1, 4'd6, 0);

        repeat (400) rnd_step(64);
        while (m_busy_left != 0) idle();

        // Clear pulse with an in-flight read; a write during the sweep is lost.
        wr(4'd9, 32'hDEAD_BEEF, 4'b1111);
        step(1, 0, 4'h0, 4'h0, 32'h0, 1, 4'd9, 1);
        wr(4'd9, 32'h1234_5678, 4'b1111);
        step(0, 0, 4'h0, 4'h0, 32'h0, 0, 4'h0, 1);
        while (m_busy_left != 0) idle();
        rd(4'd9);

        wr(4'd2, 32'h0F0F_7E81, 4'b1111);
`ifdef RAM_SDP_PARITY_EN
        dut.r_par[2][0] = ~dut.r_par[2][0];
        m_bad[2][0] = 1'b1;
`endif
        rd(4'd2);
        rd(4'd3);

        // Reset in the middle of a sweep restarts it from the beginning.
        wr(4'd7, 32'hCAFE_F00D, 4'b1111);
        step(1, 0, 4'h0, 4'h0, 32'h0, 1, 4'd7, 1);
        repeat (7) rnd_step(0);
        #1;
        rstn = 1'b0;
        m_last = '0;
        sb.delete();
        #1 check_reset_outputs("midsweep");
        @(posedge clk);
        #1 rstn = 1'b1;
        m_busy_left = 16;
        model_wipe();
        repeat (16) rnd_step(0);
        rd(4'd7);
        rd(4'd2);

        repeat (100) rnd_step(0);
        repeat (RD_LAT + 3) idle();
        chk(sb.size() == 0, "scoreboard_drained", sb.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ram_sdp.md
RAM_SDP -- requirements
Module: ram_sdp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, address width; depth = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter RD_LATENCY, default 1, read latency in cycles; legal values 1 and 2.
REQ-004 SHALL have parameter COLLISION_MODE, default 0, same-address read/write policy: 0 = read-first, 1 = write-first.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 i_clk_ram  in  1  clock; all state on rising edge.
REQ-007 i_rstn_ram  in  1  asynchronous active-low reset.
REQ-008 i_en_ram  in  1  global enable; gates both ports.
REQ-009 i_we_ram  in  1  write request.
REQ-010 i_be_ram  in  DATA_WIDTH/8  byte enables; bit n covers bits 8n+7:8n.
REQ-011 i_waddr_ram  in  ADDR_WIDTH  write address.
REQ-012 i_wdata_ram  in  DATA_WIDTH  write data.
REQ-013 i_re_ram  in  1  read request.
REQ-014 i_raddr_ram  in  ADDR_WIDTH  read address.
REQ-015 i_clr_ram  in  1  start a clear sweep (pulse).
REQ-016 o_rdata_ram  out  DATA_WIDTH  read data.
REQ-017 o_rvalid_ram  out  1  one-cycle pulse marking o_rdata_ram valid.
REQ-018 o_busy_ram  out  1  clear sweep in progress.
REQ-019 o_perr_ram  out  1  parity error, qualified by o_rvalid_ram.

Function
REQ-020 SHALL implement a two-state FSM: CLEAR and IDLE.
REQ-021 CLEAR SHALL write zero to addresses 0..2**ADDR_WIDTH-1, one per cycle, then enter IDLE; o_busy_ram = 1 throughout CLEAR.
REQ-022 i_clr_ram = 1 in IDLE SHALL enter CLEAR on the next edge; i_clr_ram during CLEAR SHALL be ignored and SHALL NOT restart the sweep.
REQ-023 Write accepted iff i_en_ram & i_we_ram & !o_busy_ram; only bytes with i_be_ram set SHALL be updated; i_be_ram = 0 leaves the word unchanged.
REQ-024 Read accepted iff i_en_ram & i_re_ram & !o_busy_ram; o_rdata_ram and o_rvalid_ram SHALL appear exactly RD_LATENCY cycles after the accepting edge.
REQ-025 Reads SHALL be fully pipelined: back-to-back accepts SHALL give back-to-back o_rvalid_ram pulses in request order.
REQ-026 o_rdata_ram SHALL hold its last value while o_rvalid_ram = 0.
REQ-027 Requests during CLEAR SHALL be dropped; no o_rvalid_ram is produced for them.
REQ-028 Reads already in the pipeline when CLEAR starts SHALL still complete.
REQ-029 On a same-cycle read and write to the same address, COLLISION_MODE 0 SHALL return the old word.
REQ-030 Under the same collision, COLLISION_MODE 1 SHALL return the merged word: enabled bytes new, other bytes old.
REQ-031 Writes to different addresses in the same cycle as a read SHALL NOT affect the read data.

Reset
REQ-032 Reset assertion SHALL immediately force o_rdata_ram = 0, o_rvalid_ram = 0, o_perr_ram = 0, o_busy_ram = 1, and clear the read pipeline.
REQ-033 Reset SHALL set the FSM to CLEAR with sweep address 0; the sweep starts on the first edge after deassertion.
REQ-034 Reset asserted mid-sweep SHALL restart the sweep from address 0.
REQ-035 The memory array SHALL NOT be asynchronously reset; it is cleared only by the sweep.

Configuration
REQ-036 Macro RAM_SDP_PARITY_EN defined: each byte SHALL store one even-parity bit, computed on write (zero-data parity during CLEAR).
REQ-037 With RAM_SDP_PARITY_EN defined, the stored parity SHALL be checked on every read, and o_perr_ram = 1 with o_rvalid_ram if any byte mismatches.
REQ-038 Macro RAM_SDP_PARITY_EN undefined: no parity storage SHALL exist, and o_perr_ram SHALL be tied 0.

Verification (DATA_WIDTH = 32, ADDR_WIDTH = 4)
REQ-039 Release reset -> o_busy_ram high exactly 16 cycles, then 0; reading addresses 0..15 returns 0x00000000 each, o_perr_ram = 0.
REQ-040 Write 0xA5A51234 to address 3 with be = 4'b1111, then 0xFFFFFFFF with be = 4'b0001, then read address 3 -> 0xA5A512FF; o_rvalid_ram arrives 1 cycle after accept (RD_LATENCY = 1) or 2 cycles (RD_LATENCY = 2).
REQ-041 Address 5 holds 0x11111111; same cycle write 0x22222222 (be = 4'b1111) and read address 5 -> 0x11111111 (mode 0) or 0x22222222 (mode 1); a following read returns 0x22222222.
REQ-042 Pulse i_clr_ram after writing 0xDEADBEEF to address 9; write 0x12345678 to address 9 during busy -> dropped; after busy falls, read address 9 -> 0x00000000.
REQ-043 Assert reset on sweep cycle 7 -> outputs reset values immediately; after release, o_busy_ram stays high for a full 16 cycles.
REQ-044 With RAM_SDP_PARITY_EN, force-invert the stored parity bit of byte 0 at address 2, then read address 2 -> o_perr_ram = 1 with o_rvalid_ram; without the macro -> o_perr_ram = 0.
